// File: rtl/fetch_queue_pkg.sv
// Shared configuration and types for the fetch queue: depth constant and state encoding.
package fetch_queue_pkg;

  localparam int unsigned FQ_DEPTH_BITS_CFG = 2;

  typedef enum logic {
    S_FLOW   = 1'b0,
    S_REPLAY = 1'b1
  } fq_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Decoupling queue between fetch and decode; drops on overflow and requests a replay
// from the dropped pc, then filters stale in-flight fetches until that pc returns.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned FQ_DEPTH_BITS = FQ_DEPTH_BITS_CFG
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        kill,
  input  logic        i_valid,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_npc,
  input  logic        d_ready,
  output logic        d_valid,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_npc,
  output logic        fq_restart,
  output logic [31:0] fq_restart_pc
);

  localparam int unsigned DEPTH = 1 << FQ_DEPTH_BITS;
  localparam logic [FQ_DEPTH_BITS:0] FULL_CNT = (FQ_DEPTH_BITS + 1)'(DEPTH);

  typedef logic [FQ_DEPTH_BITS-1:0] ptr_t;

  logic [31:0] instr_q [DEPTH];
  logic [31:0] pc_q    [DEPTH];
  logic [31:0] npc_q   [DEPTH];

  ptr_t                 rd_ptr;
  ptr_t                 wr_ptr;
  logic [FQ_DEPTH_BITS:0] count;
  logic [FQ_DEPTH_BITS:0] count_nxt;
  fq_state_e            state;
  logic [31:0]          replay_pc;

  logic deq;
  logic room;
  logic pc_match;
  logic enq;

  always_comb begin
    deq      = (count != '0) & d_ready;
    room     = (count != FULL_CNT) | deq;
    pc_match = (i_pc == replay_pc);
    enq      = ~kill & i_valid & room & ((state == S_FLOW) | pc_match);
    count_nxt = count;
    case ({enq, deq})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      state         <= S_FLOW;
      replay_pc     <= '0;
      fq_restart    <= 1'b0;
      fq_restart_pc <= '0;
    end else if (kill) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      state      <= S_FLOW;
      fq_restart <= 1'b0;
    end else begin
      rd_ptr     <= rd_ptr + ptr_t'(deq);
      wr_ptr     <= wr_ptr + ptr_t'(enq);
      count      <= count_nxt;
      fq_restart <= 1'b0;
      case (state)
        S_FLOW: begin
          if (i_valid && !room) begin
            fq_restart    <= 1'b1;
            fq_restart_pc <= i_pc;
            replay_pc     <= i_pc;
            state         <= S_REPLAY;
          end
        end
        S_REPLAY: begin
          // A re-pulse is withheld while one is already out so requests never abut.
          if (i_valid && pc_match) begin
            if (room) begin
              state <= S_FLOW;
            end else if (!fq_restart) begin
              fq_restart    <= 1'b1;
              fq_restart_pc <= i_pc;
            end
          end
        end
        default: state <= S_FLOW;
      endcase
    end
  end

  // Entry payload carries no reset; validity is tracked solely by count.
  always_ff @(posedge clock) begin
    if (enq) begin
      instr_q[wr_ptr] <= i_instr;
      pc_q[wr_ptr]    <= i_pc;
      npc_q[wr_ptr]   <= i_npc;
    end
  end

  assign d_valid = (count != '0);
  assign d_instr = instr_q[rd_ptr];
  assign d_pc    = pc_q[rd_ptr];
  assign d_npc   = npc_q[rd_ptr];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed scenario bench for fetch_queue: streaming, overflow/replay, full bypass, kill, reset.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic        clock = 1'b0;
  logic        reset, kill, i_valid, d_ready;
  logic [31:0] i_instr, i_pc, i_npc;
  logic        d_valid, fq_restart;
  logic [31:0] d_instr, d_pc, d_npc, fq_restart_pc;

  int checks = 0;
  int errors = 0;

  fetch_queue #(.FQ_DEPTH_BITS(2)) dut (
    .clock(clock), .reset(reset), .kill(kill),
    .i_valid(i_valid), .i_instr(i_instr), .i_pc(i_pc), .i_npc(i_npc),
    .d_ready(d_ready), .d_valid(d_valid), .d_instr(d_instr), .d_pc(d_pc), .d_npc(d_npc),
    .fq_restart(fq_restart), .fq_restart_pc(fq_restart_pc)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    i_valid = v;
    i_pc    = pc;
    i_instr = pc ^ 32'hDEAD_0000;
    i_npc   = pc + 32'd4;
  endtask

  task automatic test_reset();
    reset = 1'b1; kill = 1'b0; d_ready = 1'b0; drive(1'b0, 32'h0);
    step(); step();
    reset = 1'b0;
    checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL reset_d_valid got %b want 0", d_valid); end
    checks++; if (fq_restart !== 1'b0) begin errors++; $display("FAIL reset_restart got %b want 0", fq_restart); end
    checks++; if (fq_restart_pc !== 32'h0) begin errors++; $display("FAIL reset_restart_pc got %h want 0", fq_restart_pc); end
    checks++; if (dut.state !== S_FLOW) begin errors++; $display("FAIL reset_state got %0d want S_FLOW", dut.state); end
  endtask

  task automatic test_stream();
    logic [31:0] pcs [3] = '{32'h100, 32'h104, 32'h108};
    d_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pcs[i]);
      step();
      checks++; if (d_valid !== 1'b1 || d_pc !== pcs[i]) begin errors++; $display("FAIL stream_head[%0d] got v=%b pc=%h want v=1 pc=%h", i, d_valid, d_pc, pcs[i]); end
      checks++; if (d_instr !== (pcs[i] ^ 32'hDEAD_0000) || d_npc !== pcs[i] + 32'd4) begin errors++; $display("FAIL stream_fields[%0d] got instr=%h npc=%h", i, d_instr, d_npc); end
      checks++; if (dut.count !== 3'd1) begin errors++; $display("FAIL stream_count[%0d] got %0d want 1", i, dut.count); end
    end
    drive(1'b0, 32'h0);
    step();
    checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %b want 0", d_valid); end
  endtask

  task automatic test_overflow();
    d_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i));
      step();
      if (i < 4) begin
        checks++; if (fq_restart !== 1'b0) begin errors++; $display("FAIL ovf_early_restart[%0d] got %b want 0", i, fq_restart); end
      end
    end
    checks++; if (fq_restart !== 1'b1 || fq_restart_pc !== 32'h210) begin errors++; $display("FAIL ovf_restart got %b pc=%h want 1 pc=00000210", fq_restart, fq_restart_pc); end
    checks++; if (dut.count !== 3'd4 || d_pc !== 32'h200) begin errors++; $display("FAIL ovf_held got count=%0d pc=%h want 4 pc=00000200", dut.count, d_pc); end
    checks++; if (dut.state !== S_REPLAY) begin errors++; $display("FAIL ovf_state got %0d want S_REPLAY", dut.state); end
    drive(1'b0, 32'h0);
    step();
    checks++; if (fq_restart !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle got %b want 0", fq_restart); end
  endtask

  task automatic test_replay();
    logic [31:0] order [4] = '{32'h208, 32'h20C, 32'h210, 32'h0};
    drive(1'b1, 32'h214);
    step();
    checks++; if (fq_restart !== 1'b0 || dut.count !== 3'd4 || dut.state !== S_REPLAY) begin errors++; $display("FAIL replay_stale got r=%b count=%0d st=%0d want 0 4 REPLAY", fq_restart, dut.count, dut.state); end
    drive(1'b1, 32'h210);
    step();
    checks++; if (fq_restart !== 1'b1 || fq_restart_pc !== 32'h210 || dut.state !== S_REPLAY) begin errors++; $display("FAIL replay_noroom got r=%b pc=%h st=%0d want 1 00000210 REPLAY", fq_restart, fq_restart_pc, dut.state); end
    d_ready = 1'b1;
    step();
    checks++; if (fq_restart !== 1'b0 || dut.state !== S_FLOW || dut.count !== 3'd4 || d_pc !== 32'h204) begin errors++; $display("FAIL replay_accept got r=%b st=%0d count=%0d pc=%h want 0 FLOW 4 00000204", fq_restart, dut.state, dut.count, d_pc); end
    drive(1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      if (i < 3) begin
        checks++; if (d_valid !== 1'b1 || d_pc !== order[i]) begin errors++; $display("FAIL replay_order[%0d] got v=%b pc=%h want 1 %h", i, d_valid, d_pc, order[i]); end
      end else begin
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL replay_empty got %b want 0", d_valid); end
      end
    end
  endtask

  task automatic test_full_bypass();
    logic [31:0] order [4] = '{32'h288, 32'h28C, 32'h300, 32'h0};
    d_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h280 + 32'(4 * i));
      step();
    end
    d_ready = 1'b1;
    drive(1'b1, 32'h300);
    step();
    checks++; if (fq_restart !== 1'b0 || dut.count !== 3'd4 || d_pc !== 32'h284) begin errors++; $display("FAIL bypass got r=%b count=%0d pc=%h want 0 4 00000284", fq_restart, dut.count, d_pc); end
    drive(1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      if (i < 3) begin
        checks++; if (d_valid !== 1'b1 || d_pc !== order[i]) begin errors++; $display("FAIL bypass_order[%0d] got v=%b pc=%h want 1 %h", i, d_valid, d_pc, order[i]); end
      end else begin
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL bypass_empty got %b want 0", d_valid); end
      end
    end
  endtask

  task automatic test_kill();
    d_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h400 + 32'(4 * i));
      step();
    end
    d_ready = 1'b1;
    drive(1'b0, 32'h0);
    step();
    checks++; if (dut.count !== 3'd3 || dut.state !== S_REPLAY) begin errors++; $display("FAIL kill_setup got count=%0d st=%0d want 3 REPLAY", dut.count, dut.state); end
    d_ready = 1'b0; kill = 1'b1;
    drive(1'b1, 32'h500);
    step();
    kill = 1'b0;
    checks++; if (d_valid !== 1'b0 || fq_restart !== 1'b0 || dut.state !== S_FLOW) begin errors++; $display("FAIL kill_flush got v=%b r=%b st=%0d want 0 0 FLOW", d_valid, fq_restart, dut.state); end
    step();
    checks++; if (d_valid !== 1'b1 || d_pc !== 32'h500) begin errors++; $display("FAIL kill_next got v=%b pc=%h want 1 00000500", d_valid, d_pc); end
    // fill to full, then an overflowing fetch coincident with kill must not request a replay
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 32'h500 + 32'(4 * i));
      step();
    end
    kill = 1'b1;
    drive(1'b1, 32'h510);
    step();
    kill = 1'b0;
    drive(1'b0, 32'h0);
    checks++; if (fq_restart !== 1'b0 || d_valid !== 1'b0) begin errors++; $display("FAIL kill_overflow got r=%b v=%b want 0 0", fq_restart, d_valid); end
  endtask

  task automatic test_reset_mid();
    d_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h600 + 32'(4 * i));
      step();
    end
    checks++; if (fq_restart !== 1'b1 || fq_restart_pc !== 32'h610) begin errors++; $display("FAIL rstmid_setup got r=%b pc=%h want 1 00000610", fq_restart, fq_restart_pc); end
    reset = 1'b1; kill = 1'b1;
    drive(1'b1, 32'h610);
    step();
    reset = 1'b0; kill = 1'b0;
    drive(1'b0, 32'h0);
    checks++; if (d_valid !== 1'b0 || fq_restart !== 1'b0 || fq_restart_pc !== 32'h0) begin errors++; $display("FAIL rstmid got v=%b r=%b pc=%h want 0 0 00000000", d_valid, fq_restart, fq_restart_pc); end
    step();
    checks++; if (fq_restart !== 1'b0 || dut.state !== S_FLOW) begin errors++; $display("FAIL rstmid_after got r=%b st=%0d want 0 FLOW", fq_restart, dut.state); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_overflow();
    test_replay();
    test_full_bypass();
    test_kill();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
